l2_request_scheduler: RTL

Sequencing arbiter between the two L1 caches (icache and dcache) and the single L2 cache port in the memory hierarchy. It grants one L1 miss/writeback at a time. It converts 128-bit L1 line transactions into 256-bit L2 line transactions: half-line select on reads, read-modify-write merge on writebacks. A starvation guard keeps back-to-back dcache traffic from locking out instruction fetch.

---
 rtl/l2_request_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/l2_request_scheduler.sv
// Arbitrates icache/dcache misses onto one 256-bit L2 port: half-line reads, read-modify-write writebacks.
// Optional starvation guard for icache enabled by defining L2SCHED_STARVE_GUARD_EN.
`timescale 1ns/1ps
module l2_request_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         icache_read,
    input  logic [15:0]  icache_address,
    output logic [127:0] icache_rdata,
    output logic         icache_resp,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [15:0]  dcache_address,
    input  logic [127:0] dcache_wdata,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [255:0] l2_wdata,
    input  logic [255:0] l2_rdata,
    input  logic         l2_resp
);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_RMW_RD, D_RMW_WR, RESP} state_t;

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t         state_q, state_d;
    logic           dsel_q, dsel_d;
    logic [10:0]    line_q, line_d;
    logic           hsel_q, hsel_d;
    logic [127:0]   wdata_q, wdata_d;
    logic [127:0]   ret_q, ret_d;
    logic [255:0]   wline_q, wline_d;
    logic           force_i, dreq, grant_d, grant_i;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{icache_address[3:0], dcache_address[3:0]};

`ifdef L2SCHED_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign force_i = icache_read && (starve_q == LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (grant_i)
            starve_d = '0;
        else if (grant_d && icache_read && starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign force_i = 1'b0;
`endif

    assign dreq    = (dcache_read || dcache_write) && !force_i;
    assign grant_d = (state_q == IDLE) && dreq;
    assign grant_i = (state_q == IDLE) && !dreq && icache_read;

    always_comb begin
        state_d = state_q;
        dsel_d  = dsel_q;
        line_d  = line_q;
        hsel_d  = hsel_q;
        wdata_d = wdata_q;
        ret_d   = ret_q;
        wline_d = wline_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    dsel_d  = 1'b1;
                    line_d  = dcache_address[15:5];
                    hsel_d  = dcache_address[4];
                    wdata_d = dcache_wdata;
                    state_d = dcache_write ? D_RMW_RD : D_RD;
                end else if (grant_i) begin
                    dsel_d  = 1'b0;
                    line_d  = icache_address[15:5];
                    hsel_d  = icache_address[4];
                    state_d = I_RD;
                end
            end
            I_RD, D_RD: begin
                if (l2_resp) begin
                    ret_d   = hsel_q ? l2_rdata[255:128] : l2_rdata[127:0];
                    state_d = RESP;
                end
            end
            D_RMW_RD: begin
                // Keep the half of the L2 line the writeback does not cover.
                if (l2_resp) begin
                    wline_d = hsel_q ? {wdata_q, l2_rdata[127:0]}
                                     : {l2_rdata[255:128], wdata_q};
                    state_d = D_RMW_WR;
                end
            end
            D_RMW_WR: begin
                if (l2_resp) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dsel_q  <= 1'b0;
            line_q  <= '0;
            hsel_q  <= 1'b0;
            wdata_q <= '0;
            ret_q   <= '0;
            wline_q <= '0;
        end else begin
            state_q <= state_d;
            dsel_q  <= dsel_d;
            line_q  <= line_d;
            hsel_q  <= hsel_d;
            wdata_q <= wdata_d;
            ret_q   <= ret_d;
            wline_q <= wline_d;
        end
    end

    assign l2_read      = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_RMW_RD);
    assign l2_write     = (state_q == D_RMW_WR);
    assign l2_address   = {line_q, 5'b0};
    assign l2_wdata     = wline_q;
    assign icache_resp  = (state_q == RESP) && !dsel_q;
    assign dcache_resp  = (state_q == RESP) && dsel_q;
    assign icache_rdata = dsel_q ? '0 : ret_q;
    assign dcache_rdata = dsel_q ? ret_q : '0;

endmodule
